// File: rtl/mpu_matrix_loader_pkg.sv
// Shared MPU determinant-path definitions: dimensions, matrix bus layout and
// loader state encoding.
package mpu_matrix_loader_pkg;

  localparam int unsigned MAX_N    = 5;
  localparam int unsigned ELEM_W   = 8;
  localparam int unsigned MATRIX_W = ELEM_W * MAX_N * MAX_N;
  localparam int unsigned RC_W     = 3;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD   = 2'd1;
  localparam logic [1:0] SETTLE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  // Bit offset of element (row,col) on the row-major 5x5 matrix bus
  function automatic int unsigned at(input logic [RC_W-1:0] row,
                                     input logic [RC_W-1:0] col);
    return ELEM_W * (32'(col) + MAX_N * 32'(row));
  endfunction

endpackage

// File: rtl/mpu_matrix_loader_if.sv
// Command, element stream, matrix bus and result handshake of the matrix loader.
interface mpu_matrix_loader_if;
  import mpu_matrix_loader_pkg::*;

  logic                  start;
  logic [7:0]            size_in;
  logic                  busy;
  logic                  error;
  logic                  elem_valid;
  logic [ELEM_W-1:0]     elem_data;
  logic                  elem_ready;
  logic [0:MATRIX_W-1]   matrix_out;
  logic [7:0]            size_out;
  logic [ELEM_W-1:0]     det_in;
  logic [ELEM_W-1:0]     result_out;
  logic                  result_valid;
  logic                  result_ready;

  modport master (
    output start, size_in, elem_valid, elem_data, det_in, result_ready,
    input  busy, error, elem_ready, matrix_out, size_out, result_out, result_valid
  );

  modport slave (
    input  start, size_in, elem_valid, elem_data, det_in, result_ready,
    output busy, error, elem_ready, matrix_out, size_out, result_out, result_valid
  );

endinterface

// File: rtl/mpu_rc_counter.sv
// Row/column position counter for an N x N row-major stream with last flag.
module mpu_rc_counter
  import mpu_matrix_loader_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            advance,
  input  logic [RC_W-1:0] n,
  output logic [RC_W-1:0] row,
  output logic [RC_W-1:0] col,
  output logic            last
);

  logic [RC_W-1:0] n_m1;

  always_comb begin
    n_m1 = n - RC_W'(1);
    last = (row == n_m1) && (col == n_m1);
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (col == n_m1) begin
        col <= '0;
        row <= row + RC_W'(1);
      end else begin
        col <= col + RC_W'(1);
      end
    end
  end

endmodule

// File: rtl/mpu_matrix_loader.sv
// Loads an N x N signed matrix from a stream onto the 5x5 matrix bus and
// returns the registered determinant over a valid/ready handshake.
module mpu_matrix_loader
  import mpu_matrix_loader_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  mpu_matrix_loader_if.slave  bus
);

  logic [1:0]      state;
  logic [RC_W-1:0] row;
  logic [RC_W-1:0] col;
  logic            last;
  logic            size_legal;
  logic            accept_start;
  logic            elem_fire;

  always_comb begin
    size_legal   = ($signed(bus.size_in) >= 8'sd1) && ($signed(bus.size_in) <= 8'sd5);
    accept_start = (state == IDLE) && bus.start && size_legal;
    elem_fire    = (state == LOAD) && bus.elem_valid;
  end

  // Handshake outputs decode from state only, so no input reaches an output
  always_comb begin
    bus.busy         = (state != IDLE);
    bus.elem_ready   = (state == LOAD);
    bus.result_valid = (state == DONE);
  end

  mpu_rc_counter u_rc_counter (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept_start),
    .advance (elem_fire),
    .n       (bus.size_out[RC_W-1:0]),
    .row     (row),
    .col     (col),
    .last    (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      bus.matrix_out <= '0;
      bus.size_out   <= '0;
      bus.result_out <= '0;
      bus.error      <= 1'b0;
    end else begin
      bus.error <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (size_legal) begin
              bus.size_out   <= bus.size_in;
              bus.matrix_out <= '0;
              state          <= LOAD;
            end else begin
              bus.error <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (bus.elem_valid) begin
            bus.matrix_out[at(row, col) +: ELEM_W] <= bus.elem_data;
            if (last) state <= SETTLE;
          end
        end
        SETTLE: begin
          bus.result_out <= bus.det_in;
          state          <= DONE;
        end
        DONE: begin
          if (bus.result_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mpu_matrix_loader.sv
// Directed bench for mpu_matrix_loader with a behavioural determinant unit.
module tb_mpu_matrix_loader;
  import mpu_matrix_loader_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic [7:0] vals [25];

  mpu_matrix_loader_if bus();

  mpu_matrix_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Fraction-free (Bareiss) elimination stands in for the determinant unit
  function automatic logic [7:0] det_model(input logic [0:199] m, input logic [7:0] sz);
    longint a [5][5];
    longint prev, sgn, t, d;
    int unsigned nn;
    int unsigned p;
    logic [7:0] e;
    if ($signed(sz) < 1 || $signed(sz) > 5) return 8'd0;
    nn = 32'(sz);
    for (int unsigned r = 0; r < 5; r++)
      for (int unsigned c = 0; c < 5; c++) begin
        e = m[8*(c+5*r) +: 8];
        a[r][c] = longint'($signed(e));
      end
    prev = 1;
    sgn  = 1;
    for (int unsigned k = 0; k + 1 < nn; k++) begin
      if (a[k][k] == 0) begin
        p = k;
        for (int unsigned i = k + 1; i < nn; i++)
          if (p == k && a[i][k] != 0) p = i;
        if (p == k) return 8'd0;
        for (int unsigned j = 0; j < nn; j++) begin
          t = a[k][j]; a[k][j] = a[p][j]; a[p][j] = t;
        end
        sgn = -sgn;
      end
      for (int unsigned i = k + 1; i < nn; i++)
        for (int unsigned j = k + 1; j < nn; j++)
          a[i][j] = (a[i][j] * a[k][k] - a[i][k] * a[k][j]) / prev;
      prev = a[k][k];
    end
    d = sgn * a[nn-1][nn-1];
    return d[7:0];
  endfunction

  always_comb bus.det_in = det_model(bus.matrix_out, bus.size_out);

  task automatic check(input string tag, input logic [199:0] got, input logic [199:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] n);
    bus.start   = 1'b1;
    bus.size_in = n;
    tick();
    bus.start   = 1'b0;
  endtask

  task automatic send_elem(input logic [7:0] v, input int unsigned gap);
    int unsigned budget;
    for (int unsigned g = 0; g < gap; g++) tick();
    bus.elem_valid = 1'b1;
    bus.elem_data  = v;
    budget = 0;
    while (bus.elem_ready !== 1'b1 && budget < 20) begin
      tick();
      budget++;
    end
    if (budget >= 20) check("elem_ready_timeout", 200'(bus.elem_ready), 200'(1));
    tick();
    bus.elem_valid = 1'b0;
  endtask

  task automatic load(input int unsigned n, input int unsigned max_gap);
    for (int unsigned i = 0; i < n * n; i++)
      send_elem(vals[i], (max_gap == 0) ? 0 : $urandom_range(0, max_gap));
  endtask

  function automatic logic [0:199] exp_matrix(input int unsigned n);
    logic [0:199] m;
    m = '0;
    for (int unsigned r = 0; r < n; r++)
      for (int unsigned c = 0; c < n; c++)
        m[8*(c+5*r) +: 8] = vals[r*n + c];
    return m;
  endfunction

  task automatic take_result(input string tag, input logic [7:0] exp);
    check({tag, "_settle_valid"}, 200'(bus.result_valid), 200'(0));
    tick();
    check({tag, "_valid"}, 200'(bus.result_valid), 200'(1));
    check({tag, "_result"}, 200'(bus.result_out), 200'(exp));
    bus.result_ready = 1'b1;
    tick();
    bus.result_ready = 1'b0;
    check({tag, "_idle_busy"}, 200'(bus.busy), 200'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.size_in = '0;
    bus.elem_valid = 1'b0;
    bus.elem_data = '0;
    bus.result_ready = 1'b0;
    tick();
    tick();
    check("rst_matrix", 200'(bus.matrix_out), 200'(0));
    check("rst_outs", 200'({bus.busy, bus.error, bus.elem_ready, bus.result_valid,
                            bus.size_out, bus.result_out}), 200'(0));
    rst = 1'b0;
    tick();

    // 1: N=2 back-to-back, latency check
    vals[0] = 8'd3; vals[1] = 8'hFF; vals[2] = 8'd4; vals[3] = 8'd3;
    do_start(8'd2);
    check("t1_ready", 200'(bus.elem_ready), 200'(1));
    check("t1_size", 200'(bus.size_out), 200'(2));
    load(2, 0);
    check("t1_elem_ready_settle", 200'(bus.elem_ready), 200'(0));
    take_result("t1", 8'd13);

    // 2: N=4 with gaps
    vals = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8,
             8'd2, 8'd1, 8'd2, 8'd1, 8'd2, 8'd2, 8'd1, 8'd6,
             8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    do_start(8'd4);
    load(4, 3);
    check("t2_matrix", 200'(bus.matrix_out), 200'(exp_matrix(4)));
    take_result("t2", 8'hD8);

    // 3: N=5 identity, then N=1
    for (int unsigned i = 0; i < 25; i++) vals[i] = (i % 6 == 0) ? 8'd1 : 8'd0;
    do_start(8'd5);
    load(5, 1);
    check("t3_matrix", 200'(bus.matrix_out), 200'(exp_matrix(5)));
    take_result("t3_id", 8'd1);
    do_start(8'd1);
    check("t3_cleared", 200'(bus.matrix_out), 200'(0));
    vals[0] = 8'hF9;
    load(1, 0);
    check("t3_n1_matrix", 200'(bus.matrix_out), 200'(exp_matrix(1)));
    take_result("t3_n1", 8'hF9);

    // 4: illegal sizes
    do_start(8'd0);
    check("t4_err0", 200'({bus.error, bus.busy, bus.elem_ready}), 200'(3'b100));
    tick();
    check("t4_err0_pulse", 200'({bus.error, bus.busy, bus.elem_ready}), 200'(0));
    do_start(8'd6);
    check("t4_err6", 200'({bus.error, bus.busy, bus.elem_ready}), 200'(3'b100));
    check("t4_size_hold", 200'(bus.size_out), 200'(1));
    tick();
    check("t4_err6_pulse", 200'({bus.error, bus.busy, bus.elem_ready}), 200'(0));

    // 5: back-pressure in DONE
    vals[0] = 8'd1; vals[1] = 8'd2; vals[2] = 8'd3; vals[3] = 8'd4;
    do_start(8'd2);
    load(2, 0);
    tick();
    for (int unsigned i = 0; i < 3; i++) begin
      if (i == 1) begin
        bus.start = 1'b1;
        bus.size_in = 8'd3;
      end
      tick();
      bus.start = 1'b0;
      check("t5_hold", 200'({bus.result_valid, bus.error, bus.result_out, bus.size_out}),
            200'({1'b1, 1'b0, 8'hFE, 8'd2}));
    end
    bus.result_ready = 1'b1;
    tick();
    bus.result_ready = 1'b0;
    check("t5_release", 200'({bus.busy, bus.result_valid}), 200'(0));

    // 6: reset mid-load, then fresh load
    vals[0] = 8'd2; vals[1] = 8'd1; vals[2] = 8'd0;
    vals[3] = 8'd1; vals[4] = 8'd3; vals[5] = 8'd1;
    vals[6] = 8'd0; vals[7] = 8'd1; vals[8] = 8'd4;
    do_start(8'd3);
    for (int unsigned i = 0; i < 5; i++) send_elem(vals[i], 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_rst_matrix", 200'(bus.matrix_out), 200'(0));
    check("t6_rst_outs", 200'({bus.busy, bus.error, bus.elem_ready, bus.result_valid,
                               bus.size_out, bus.result_out}), 200'(0));
    do_start(8'd3);
    load(3, 0);
    take_result("t6", 8'd18);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
